// File: rtl/sum_it_accum.sv
// Packet accumulator: sums up to MAX_CNT consecutive words after an active-low go_l,
// exposing the running sum every cycle and the final total with a one-cycle done pulse.
module sum_it_accum #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_CNT = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] inA,
  input  logic             go_l,
  input  logic [7:0]       howMany,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] outResult,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(MAX_CNT + 1);
  localparam logic [7:0]      MaxCnt8 = 8'(MAX_CNT);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_CNT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [CntW-1:0]  n_clamp;
  logic [WIDTH:0]   add_full;

  // Oversized requests are clamped rather than rejected.
  assign n_clamp  = (howMany > MaxCnt8) ? MaxCnt : howMany[CntW-1:0];
  assign add_full = {1'b0, sum_q} + {1'b0, inA};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sum_d   = sum_q;
    res_d   = res_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (!go_l) begin
          ovf_d = 1'b0;
          if (n_clamp == '0) begin
            sum_d  = '0;
            res_d  = '0;
            done_d = 1'b1;
          end else if (n_clamp == CntOne) begin
            sum_d  = inA;
            res_d  = inA;
            done_d = 1'b1;
          end else begin
            sum_d   = inA;
            cnt_d   = n_clamp - CntOne;
            busy_d  = 1'b1;
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        // go_l is deliberately ignored here: a packet always runs to completion.
        sum_d = add_full[WIDTH-1:0];
        ovf_d = ovf_q | add_full[WIDTH];
        if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          cnt_d   = '0;
          res_d   = add_full[WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      sum_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign sum       = sum_q;
  assign outResult = res_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_it_accum.sv
// Self-checking bench for sum_it_accum: directed scenarios plus randomized packets
// compared cycle by cycle against a prefix-sum reference model.
module tb_sum_it_accum;

  logic        clk;
  logic        rst_l;
  logic [15:0] inA;
  logic        go_l;
  logic [7:0]  howMany;
  logic        busy;
  logic [15:0] sum;
  logic [15:0] outResult;
  logic        done;
  logic        ovf;

  int n_checks;
  int n_fail;

  // Reference state carried between packets.
  logic [15:0] exp_res;
  logic [15:0] exp_sum;
  logic        exp_ovf;
  logic [15:0] pkt_w [5];

  sum_it_accum #(
    .WIDTH  (16),
    .MAX_CNT(5)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .inA      (inA),
    .go_l     (go_l),
    .howMany  (howMany),
    .busy     (busy),
    .sum      (sum),
    .outResult(outResult),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one packet starting now (possibly inside a done cycle) and checks every cycle.
  // noise=1 holds go_l low throughout the remaining words of the packet.
  task automatic run_packet(input int hm, input bit noise);
    int n;
    int run;
    int t;
    bit ov;
    bit last;
    n   = (hm > 5) ? 5 : hm;
    run = 0;
    ov  = 1'b0;
    for (int k = 0; k < ((n == 0) ? 1 : n); k++) begin
      go_l    = (k == 0) ? 1'b0 : (noise ? 1'b0 : 1'b1);
      howMany = (k == 0) ? 8'(hm) : 8'($urandom);
      inA     = (n == 0) ? 16'($urandom) : pkt_w[k];
      if (n == 0) run = 0;
      else if (k == 0) run = int'(pkt_w[0]);
      else begin
        t = run + int'(pkt_w[k]);
        if (t > 65535) ov = 1'b1;
        run = t % 65536;
      end
      @(posedge clk);
      #1;
      last = (k == ((n == 0) ? 0 : n - 1));
      if (last) exp_res = 16'(run);
      n_checks += 5;
      if (sum !== 16'(run)) begin
        n_fail++;
        $display("FAIL pkt_sum hm=%0d k=%0d got=%h want=%h", hm, k, sum, 16'(run));
      end
      if (busy !== !last) begin
        n_fail++;
        $display("FAIL pkt_busy hm=%0d k=%0d got=%b want=%b", hm, k, busy, !last);
      end
      if (done !== last) begin
        n_fail++;
        $display("FAIL pkt_done hm=%0d k=%0d got=%b want=%b", hm, k, done, last);
      end
      if (outResult !== exp_res) begin
        n_fail++;
        $display("FAIL pkt_result hm=%0d k=%0d got=%h want=%h", hm, k, outResult, exp_res);
      end
      if (ovf !== ov) begin
        n_fail++;
        $display("FAIL pkt_ovf hm=%0d k=%0d got=%b want=%b", hm, k, ovf, ov);
      end
    end
    go_l    = 1'b1;
    howMany = 8'($urandom);
    inA     = 16'($urandom);
    exp_sum = 16'(run);
    exp_ovf = ov;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      go_l    = 1'b1;
      howMany = 8'($urandom);
      inA     = 16'($urandom);
      @(posedge clk);
      #1;
      n_checks += 5;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_done got=%b want=0", done);
      end
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_busy got=%b want=0", busy);
      end
      if (sum !== exp_sum) begin
        n_fail++;
        $display("FAIL idle_sum got=%h want=%h", sum, exp_sum);
      end
      if (outResult !== exp_res) begin
        n_fail++;
        $display("FAIL idle_result got=%h want=%h", outResult, exp_res);
      end
      if (ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL idle_ovf got=%b want=%b", ovf, exp_ovf);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({busy, sum, outResult, done, ovf} !== 35'd0) begin
      n_fail++;
      $display("FAIL %s busy=%b sum=%h res=%h done=%b ovf=%b want all 0",
               tag, busy, sum, outResult, done, ovf);
    end
  endtask

  task automatic test_reset();
    rst_l   = 1'b0;
    go_l    = 1'b0;
    howMany = 8'd3;
    inA     = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_l   = 1'b1;
    exp_res = '0;
    exp_sum = '0;
    exp_ovf = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    pkt_w[0] = 16'd55;
    pkt_w[1] = 16'd22;
    pkt_w[2] = 16'd11;
    run_packet(3, 1'b0);
    n_checks++;
    if (outResult !== 16'd88 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_total got=%0d ovf=%b want=88 ovf=0", outResult, ovf);
    end
    idle(2);
  endtask

  task automatic test_single();
    pkt_w[0] = 16'd7;
    run_packet(1, 1'b0);
    n_checks++;
    if (outResult !== 16'd7) begin
      n_fail++;
      $display("FAIL single_total got=%0d want=7", outResult);
    end
    idle(1);
  endtask

  task automatic test_wrap();
    pkt_w[0] = 16'hFFFF;
    pkt_w[1] = 16'd2;
    run_packet(2, 1'b0);
    n_checks++;
    if (outResult !== 16'd1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_total got=%0d ovf=%b want=1 ovf=1", outResult, ovf);
    end
    idle(2);
    pkt_w[0] = 16'd3;
    run_packet(1, 1'b0);
    n_checks++;
    if (outResult !== 16'd3 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear got=%0d ovf=%b want=3 ovf=0", outResult, ovf);
    end
    idle(1);
  endtask

  task automatic test_zero_clamp();
    pkt_w[0] = 16'd99;
    run_packet(0, 1'b0);
    n_checks++;
    if (outResult !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_total got=%0d want=0", outResult);
    end
    idle(1);
    for (int i = 0; i < 5; i++) pkt_w[i] = 16'd1;
    run_packet(9, 1'b0);
    n_checks++;
    if (outResult !== 16'd5) begin
      n_fail++;
      $display("FAIL clamp_total got=%0d want=5", outResult);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    pkt_w[0] = 16'd1;
    pkt_w[1] = 16'd2;
    pkt_w[2] = 16'd3;
    run_packet(3, 1'b1);
    n_checks++;
    if (outResult !== 16'd6) begin
      n_fail++;
      $display("FAIL midgo_total got=%0d want=6", outResult);
    end
    pkt_w[0] = 16'd10;
    pkt_w[1] = 16'd20;
    run_packet(2, 1'b0);
    n_checks++;
    if (outResult !== 16'd30) begin
      n_fail++;
      $display("FAIL b2b_total got=%0d want=30", outResult);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_packet();
    go_l    = 1'b0;
    howMany = 8'd3;
    inA     = 16'd4;
    @(posedge clk);
    #1;
    go_l = 1'b1;
    inA  = 16'd5;
    @(posedge clk);
    #1;
    n_checks++;
    if (sum !== 16'd9 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre sum=%0d busy=%b want sum=9 busy=1", sum, busy);
    end
    rst_l = 1'b0;
    #1;
    check_all_zero("midrst_async");
    @(posedge clk);
    #1;
    check_all_zero("midrst_held");
    rst_l   = 1'b1;
    exp_res = '0;
    exp_sum = '0;
    exp_ovf = 1'b0;
    idle(1);
    pkt_w[0] = 16'd100;
    pkt_w[1] = 16'd200;
    pkt_w[2] = 16'd300;
    run_packet(3, 1'b0);
    n_checks++;
    if (outResult !== 16'd600) begin
      n_fail++;
      $display("FAIL midrst_after got=%0d want=600", outResult);
    end
    idle(1);
  endtask

  task automatic test_random();
    int hm;
    for (int p = 0; p < 40; p++) begin
      hm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 255)) : int'($urandom_range(0, 5));
      for (int i = 0; i < 5; i++)
        pkt_w[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                                : 16'($urandom);
      run_packet(hm, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_l    = 1'b0;
    go_l     = 1'b1;
    howMany  = '0;
    inA      = '0;
    exp_res  = '0;
    exp_sum  = '0;
    exp_ovf  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_zero_clamp();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
